// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory ("code" mode).
// Accepts a byte stream over valid/ready: a 16-bit big-endian word count N,
// then N big-endian 32-bit instruction words. Each word is written to
// BASE_ADDR + index. core_run stays low until the image has been loaded.
// Optional feature, macro IMEM_LOADER_CHECKSUM_EN: a trailing checksum byte
// (XOR of all header and data bytes) is verified before core_run is released.
// A load ends in two steps. The edge that accepts the final byte enters
// DONE/ERR and drops in_ready. The following edge updates busy/core_run/err,
// so the last word's im_we pulse is already complete when core_run rises.
module imem_loader #(
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              core_run,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   // Largest word count that fits above BASE_ADDR without wrapping.
   localparam int unsigned       CAPACITY = unsigned'(DEPTH - BASE_ADDR);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM, ST_DONE, ST_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR0, ST_HDR1, ST_DATA, ST_DONE, ST_ERR
   } state_t;
`endif

   state_t            state_reg;
   logic              in_ready_reg;
   logic              im_we_reg;
   logic [ADDR_W-1:0] im_addr_reg;
   logic [31:0]       im_wdata_reg;
   logic              core_run_reg;
   logic              busy_reg;
   logic              err_reg;
   logic [ADDR_W:0]   words_loaded_reg;
   logic [7:0]        hdr_hi_reg;
   logic [15:0]       word_count_reg;
   logic [1:0]        byte_cnt_reg;
   logic [23:0]       partial_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_reg;
`endif

   logic              accept;
   logic              start_ok;
   logic              last_word;
   logic [15:0]       hdr_count;
   logic [31:0]       word_next;
   logic [ADDR_W-1:0] word_addr;

   // A byte moves only on a valid/ready handshake.
   assign accept    = in_valid && in_ready_reg;
   // load_start is honoured only when no load is in flight.
   assign start_ok  = load_start &&
                      (state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERR);
   // Full word count, once the low header byte is on the bus.
   assign hdr_count = {hdr_hi_reg, in_data};
   // Completed word, once the fourth byte is on the bus.
   assign word_next = {partial_reg, in_data};
   assign word_addr = BASE + words_loaded_reg[ADDR_W-1:0];
   // The word being completed now is the final one of the image.
   assign last_word = (32'(words_loaded_reg) + 32'd1) == 32'(word_count_reg);

   // Load sequencer: header parse, word assembly, memory writes and status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         in_ready_reg     <= 1'b0;
         im_we_reg        <= 1'b0;
         im_addr_reg      <= '0;
         im_wdata_reg     <= '0;
         core_run_reg     <= 1'b0;
         busy_reg         <= 1'b0;
         err_reg          <= 1'b0;
         words_loaded_reg <= '0;
         hdr_hi_reg       <= '0;
         word_count_reg   <= '0;
         byte_cnt_reg     <= '0;
         partial_reg      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_reg         <= '0;
`endif
      end else begin
         im_we_reg <= 1'b0;
         if (start_ok) begin
            state_reg        <= ST_HDR0;
            in_ready_reg     <= 1'b1;
            busy_reg         <= 1'b1;
            core_run_reg     <= 1'b0;
            err_reg          <= 1'b0;
            words_loaded_reg <= '0;
            byte_cnt_reg     <= '0;
            partial_reg      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg         <= '0;
`endif
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  in_ready_reg <= 1'b0;
               end

               ST_HDR0: begin
                  if (accept) begin
                     hdr_hi_reg <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_reg   <= csum_reg ^ in_data;
`endif
                     state_reg  <= ST_HDR1;
                  end
               end

               ST_HDR1: begin
                  if (accept) begin
                     word_count_reg <= hdr_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_reg       <= csum_reg ^ in_data;
`endif
                     if (hdr_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_reg    <= ST_CSUM;
`else
                        state_reg    <= ST_DONE;
                        in_ready_reg <= 1'b0;
`endif
                     end else if (32'(hdr_count) > CAPACITY) begin
                        // Image would not fit: refuse it before any write.
                        state_reg    <= ST_ERR;
                        in_ready_reg <= 1'b0;
                     end else begin
                        state_reg    <= ST_DATA;
                     end
                  end
               end

               ST_DATA: begin
                  if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_reg     <= csum_reg ^ in_data;
`endif
                     partial_reg  <= word_next[23:0];
                     byte_cnt_reg <= byte_cnt_reg + 2'd1;
                     if (byte_cnt_reg == 2'd3) begin
                        im_we_reg        <= 1'b1;
                        im_addr_reg      <= word_addr;
                        im_wdata_reg     <= word_next;
                        words_loaded_reg <= words_loaded_reg + (ADDR_W+1)'(1);
                        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                           state_reg    <= ST_CSUM;
`else
                           state_reg    <= ST_DONE;
                           in_ready_reg <= 1'b0;
`endif
                        end
                     end
                  end
               end

`ifdef IMEM_LOADER_CHECKSUM_EN
               ST_CSUM: begin
                  if (accept) begin
                     in_ready_reg <= 1'b0;
                     if ((csum_reg ^ in_data) == 8'd0) begin
                        state_reg <= ST_DONE;
                     end else begin
                        state_reg <= ST_ERR;
                     end
                  end
               end
`endif

               ST_DONE: begin
                  in_ready_reg <= 1'b0;
                  // Release the core one cycle after the final byte/write.
                  if (busy_reg) begin
                     busy_reg     <= 1'b0;
                     core_run_reg <= 1'b1;
                  end
               end

               ST_ERR: begin
                  in_ready_reg <= 1'b0;
                  // Flag the abort; the core stays halted.
                  if (busy_reg) begin
                     busy_reg     <= 1'b0;
                     err_reg      <= 1'b1;
                     core_run_reg <= 1'b0;
                  end
               end

               default: begin
                  state_reg    <= ST_IDLE;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign in_ready     = in_ready_reg;
   assign im_we        = im_we_reg;
   assign im_addr      = im_addr_reg;
   assign im_wdata     = im_wdata_reg;
   assign core_run     = core_run_reg;
   assign busy         = busy_reg;
   assign err          = err_reg;
   assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized byte-stream images checked against
// a word-level model of the expected instruction memory writes.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int ADDR_W    = 10;
   localparam int DEPTH     = 1024;
   localparam int BASE_ADDR = 0;

   typedef logic [7:0]  byte_q_t [$];
   typedef logic [31:0] word_q_t [$];

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load_start = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              core_run;
   logic              busy;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   int errors = 0;
   int checks = 0;

   logic [ADDR_W-1:0] obs_addr_q [$];
   logic [31:0]       obs_data_q [$];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
      .clk(clk), .rst(rst), .load_start(load_start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .core_run(core_run), .busy(busy), .err(err), .words_loaded(words_loaded)
   );

   // Write monitor: one line per memory write transaction.
   always @(negedge clk) begin
      if (!rst && im_we) begin
         obs_addr_q.push_back(im_addr);
         obs_data_q.push_back(im_wdata);
         $display("txn write addr=%0d data=%08h", im_addr, im_wdata);
      end
   end

   // Reference image builder: header, big-endian words, optional checksum.
   function automatic byte_q_t build_image(input word_q_t words);
      byte_q_t    img;
      int         n;
      logic [7:0] x;
      n = words.size();
      img.push_back(8'(n >> 8));
      img.push_back(8'(n));
      foreach (words[i])
         for (int b = 3; b >= 0; b--) img.push_back(8'(words[i] >> (8 * b)));
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (img[i]) x = x ^ img[i];
      img.push_back(x);
`else
      x = 8'h00;
      if (x != 8'h00) img.push_back(x);
`endif
      return img;
   endfunction

   function automatic word_q_t rand_words(input int n);
      word_q_t w;
      for (int i = 0; i < n; i++) w.push_back($urandom);
      return w;
   endfunction

   task automatic clear_obs();
      obs_addr_q.delete();
      obs_data_q.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   // Drives the first 'count' bytes. mode 0=continuous, 1=toggle, 2=random;
   // a 5-cycle valid gap is inserted before byte 'gap_at' (if >= 0).
   // Returns just after the edge that took the last byte.
   task automatic drive_bytes(input byte_q_t img, input int count, input int mode,
                              input int gap_at, output bit timed_out, output bit ready_dropped);
      int idx;
      int cycles;
      int gap_left;
      bit gap_done;
      bit v;
      bit xfer;
      idx = 0; cycles = 0; gap_left = 0; gap_done = 0;
      timed_out = 0; ready_dropped = 0;
      while (idx < count) begin
         @(negedge clk);
         if (idx == gap_at && !gap_done) begin
            gap_done = 1;
            gap_left = 5;
         end
         if (gap_left > 0) begin
            v = 0;
            gap_left--;
         end else if (mode == 0) v = 1;
         else if (mode == 1) v = (cycles % 2) == 0;
         else v = $urandom_range(0, 2) != 0;
         in_data  = img[idx];
         in_valid = v;
         if (!in_ready) ready_dropped = 1;
         xfer = v && in_ready;
         @(posedge clk);
         #1;
         if (xfer) idx++;
         cycles++;
         if (cycles > 2000) begin
            timed_out = 1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit timed_out);
      timed_out = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) begin
            timed_out = 0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({in_ready, im_we, core_run, busy, err} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 00000", {in_ready, im_we, core_run, busy, err});
      end
      checks++;
      if ({words_loaded, im_addr, im_wdata} !== '0) begin
         errors++; $display("FAIL reset_regs: got wl=%0d addr=%0d data=%08h expected zeros", words_loaded, im_addr, im_wdata);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL idle_ready: got %b expected 0", in_ready);
      end
   endtask

   task automatic test_continuous();
      word_q_t w;
      byte_q_t img;
      bit to, rd;
      w = '{32'h12345678, 32'hFC000000};
      img = build_image(w);
      clear_obs();
      pulse_start();
      checks++;
      if ({busy, core_run, err, in_ready} !== 4'b1001 || words_loaded !== '0) begin
         errors++; $display("FAIL start_state: got busy/run/err/rdy=%b wl=%0d expected 1001 wl=0", {busy, core_run, err, in_ready}, words_loaded);
      end
      drive_bytes(img, img.size(), 0, -1, to, rd);
      checks++;
      if (to) begin errors++; $display("FAIL cont_timeout: got timeout expected completion"); end
      @(negedge clk);
`ifndef IMEM_LOADER_CHECKSUM_EN
      checks++;
      if (im_we !== 1'b1 || im_addr !== 1 || im_wdata !== 32'hFC000000) begin
         errors++; $display("FAIL cont_last_write: got we=%b addr=%0d data=%08h expected 1 1 fc000000", im_we, im_addr, im_wdata);
      end
`endif
      checks++;
      if (core_run !== 1'b0) begin errors++; $display("FAIL cont_run_early: got %b expected 0", core_run); end
      @(negedge clk);
      checks++;
      if (core_run !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 2) begin
         errors++; $display("FAIL cont_done: got run=%b busy=%b rdy=%b wl=%0d expected 1 0 0 2", core_run, busy, in_ready, words_loaded);
      end
      checks++;
      if (obs_addr_q.size() != 2) begin
         errors++; $display("FAIL cont_wcount: got %0d expected 2", obs_addr_q.size());
      end else begin
         checks++;
         if (obs_addr_q[0] !== 0 || obs_data_q[0] !== 32'h12345678 || obs_addr_q[1] !== 1 || obs_data_q[1] !== 32'hFC000000) begin
            errors++; $display("FAIL cont_wdata: got %0d:%08h %0d:%08h expected 0:12345678 1:fc000000", obs_addr_q[0], obs_data_q[0], obs_addr_q[1], obs_data_q[1]);
         end
      end
   endtask

   task automatic test_gaps();
      word_q_t w;
      byte_q_t img;
      bit to, rd, tw;
      w = '{32'h12345678, 32'hFC000000};
      img = build_image(w);
      clear_obs();
      pulse_start();
      drive_bytes(img, img.size(), 1, 7, to, rd);
      checks++;
      if (to || rd) begin errors++; $display("FAIL gap_flow: got timeout=%b ready_drop=%b expected 0 0", to, rd); end
      wait_idle(tw);
      checks++;
      if (tw || core_run !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL gap_done: got timeout=%b run=%b rdy=%b expected 0 1 0", tw, core_run, in_ready);
      end
      checks++;
      if (obs_addr_q.size() != 2) begin
         errors++; $display("FAIL gap_wcount: got %0d expected 2", obs_addr_q.size());
      end else begin
         checks++;
         if (obs_data_q[0] !== 32'h12345678 || obs_data_q[1] !== 32'hFC000000 || obs_addr_q[1] !== 1) begin
            errors++; $display("FAIL gap_wdata: got %08h %08h expected 12345678 fc000000", obs_data_q[0], obs_data_q[1]);
         end
      end
   endtask

   task automatic test_empty();
      word_q_t w;
      byte_q_t img;
      bit to, rd;
      img = build_image(w);
      clear_obs();
      pulse_start();
      drive_bytes(img, img.size(), 0, -1, to, rd);
      @(negedge clk);
      checks++;
      if (to || core_run !== 1'b0) begin errors++; $display("FAIL empty_early: got timeout=%b run=%b expected 0 0", to, core_run); end
      @(negedge clk);
      checks++;
      if (core_run !== 1'b1 || words_loaded !== 0 || busy !== 1'b0 || obs_addr_q.size() != 0) begin
         errors++; $display("FAIL empty_done: got run=%b wl=%0d busy=%b writes=%0d expected 1 0 0 0", core_run, words_loaded, busy, obs_addr_q.size());
      end
   endtask

   task automatic test_overflow();
      byte_q_t img;
      word_q_t w;
      bit to, rd, tw;
      int bad;
      img = '{8'h04, 8'h01};
      clear_obs();
      pulse_start();
      drive_bytes(img, 2, 0, -1, to, rd);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'hAA;
         if (in_ready) bad++;
      end
      in_valid = 1'b0;
      checks++;
      if (to || bad != 0) begin errors++; $display("FAIL ovf_ready: got timeout=%b ready_cycles=%0d expected 0 0", to, bad); end
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || core_run !== 1'b0 || words_loaded !== 0 || obs_addr_q.size() != 0) begin
         errors++; $display("FAIL ovf_err: got err=%b busy=%b run=%b wl=%0d writes=%0d expected 1 0 0 0 0", err, busy, core_run, words_loaded, obs_addr_q.size());
      end
      w = rand_words(1);
      img = build_image(w);
      pulse_start();
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_restart: got err=%b busy=%b expected 0 1", err, busy); end
      drive_bytes(img, img.size(), 2, -1, to, rd);
      wait_idle(tw);
      checks++;
      if (to || tw || err !== 1'b0 || core_run !== 1'b1 || obs_addr_q.size() != 1) begin
         errors++; $display("FAIL ovf_reload: got timeout=%b/%b err=%b run=%b writes=%0d expected 0/0 0 1 1", to, tw, err, core_run, obs_addr_q.size());
      end else begin
         checks++;
         if (obs_addr_q[0] !== BASE_ADDR || obs_data_q[0] !== w[0]) begin
            errors++; $display("FAIL ovf_wdata: got %0d:%08h expected %0d:%08h", obs_addr_q[0], obs_data_q[0], BASE_ADDR, w[0]);
         end
      end
   endtask

   task automatic test_reset_midload();
      word_q_t w;
      byte_q_t img;
      bit to, rd, tw;
      w = rand_words(2);
      img = build_image(w);
      clear_obs();
      pulse_start();
      drive_bytes(img, 8, 0, -1, to, rd);
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      checks++;
      if (to || words_loaded !== 1 || busy !== 1'b1) begin
         errors++; $display("FAIL midload_ignore_start: got timeout=%b wl=%0d busy=%b expected 0 1 1", to, words_loaded, busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, im_we, core_run, busy, err} !== 5'b0 || {words_loaded, im_addr, im_wdata} !== '0) begin
         errors++; $display("FAIL async_reset: got flags=%b wl=%0d addr=%0d data=%08h expected zeros", {in_ready, im_we, core_run, busy, err}, words_loaded, im_addr, im_wdata);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (obs_addr_q.size() != 1) begin
         errors++; $display("FAIL midload_wcount: got %0d expected 1", obs_addr_q.size());
      end else begin
         checks++;
         if (obs_addr_q[0] !== BASE_ADDR || obs_data_q[0] !== w[0]) begin
            errors++; $display("FAIL midload_wdata: got %0d:%08h expected %0d:%08h", obs_addr_q[0], obs_data_q[0], BASE_ADDR, w[0]);
         end
      end
      w = rand_words(2);
      img = build_image(w);
      clear_obs();
      pulse_start();
      drive_bytes(img, img.size(), 2, 3, to, rd);
      wait_idle(tw);
      checks++;
      if (to || tw || obs_addr_q.size() != 2 || words_loaded !== 2) begin
         errors++; $display("FAIL fresh_load: got timeout=%b/%b writes=%0d wl=%0d expected 0/0 2 2", to, tw, obs_addr_q.size(), words_loaded);
      end else begin
         checks++;
         if (obs_addr_q[0] !== BASE_ADDR || obs_data_q[0] !== w[0] || obs_addr_q[1] !== BASE_ADDR + 1 || obs_data_q[1] !== w[1]) begin
            errors++; $display("FAIL fresh_wdata: got %0d:%08h %0d:%08h expected %08h %08h", obs_addr_q[0], obs_data_q[0], obs_addr_q[1], obs_data_q[1], w[0], w[1]);
         end
      end
   endtask

   task automatic test_random();
      word_q_t w;
      byte_q_t img;
      bit to, rd, tw;
      int n, bad;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 6);
         w = rand_words(n);
         img = build_image(w);
         clear_obs();
         pulse_start();
         drive_bytes(img, img.size(), $urandom_range(0, 2),
                     ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(2, img.size() - 1), to, rd);
         wait_idle(tw);
         checks++;
         if (to || tw || core_run !== 1'b1 || err !== 1'b0 || words_loaded !== (ADDR_W+1)'(n)) begin
            errors++; $display("FAIL rand_status[%0d]: got timeout=%b/%b run=%b err=%b wl=%0d expected 0/0 1 0 %0d", it, to, tw, core_run, err, words_loaded, n);
         end
         bad = 0;
         if (obs_addr_q.size() != n) bad = 1;
         else foreach (w[i]) if (obs_addr_q[i] !== ADDR_W'(BASE_ADDR + i) || obs_data_q[i] !== w[i]) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL rand_writes[%0d]: got %0d writes (%0d wrong) expected %0d", it, obs_addr_q.size(), bad, n);
         end
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      byte_q_t img;
      bit to, rd, tw;
      img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      clear_obs();
      pulse_start();
      drive_bytes(img, img.size(), 0, -1, to, rd);
      wait_idle(tw);
      checks++;
      if (to || tw || core_run !== 1'b1 || err !== 1'b0 || obs_data_q.size() != 1) begin
         errors++; $display("FAIL csum_good: got run=%b err=%b writes=%0d expected 1 0 1", core_run, err, obs_data_q.size());
      end
      img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      pulse_start();
      drive_bytes(img, img.size(), 1, -1, to, rd);
      wait_idle(tw);
      checks++;
      if (to || tw || core_run !== 1'b0 || err !== 1'b1) begin
         errors++; $display("FAIL csum_bad: got run=%b err=%b expected 0 1", core_run, err);
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_continuous();
      test_gaps();
      test_empty();
      test_overflow();
      test_reset_midload();
      test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
